// File: rtl/custom2apb_pkg.sv
// Shared types and constants for the custom-bus to APB4 bridge.
package custom2apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0]  STRB_READ     = 4'b0000;
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/custom2apb_if.sv
// Core-side valid/ready memory bus and APB4 bus bundles, each with both
// master and slave views.
interface custom2apb_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        bus_err;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, bus_err
    );
    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, bus_err
    );
endinterface

interface custom2apb_apb_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic                  PREADY;
    logic [31:0]           PRDATA;
    logic                  PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );
    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/custom2apb.sv
// Custom valid/ready responder to APB4 initiator: one SETUP/ACCESS per core transfer,
// mem_ready 3 cycles after acceptance plus PREADY waits; CUSTOM2APB_TIMEOUT_EN bounds ACCESS.
module custom2apb
    import custom2apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             resetn,
    custom2apb_mem_if.slave  mem,
    custom2apb_apb_if.master apb
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("custom2apb: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic [3:0]            pstrb_q, pstrb_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  bus_err_q, bus_err_d;

`ifdef CUSTOM2APB_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0]            cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
`ifdef CUSTOM2APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            mem_ready_q <= mem_ready_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
`ifdef CUSTOM2APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rdata_d     = rdata_q;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;
`ifdef CUSTOM2APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (mem.mem_valid) begin
                    paddr_d   = mem.mem_addr[ADDR_WIDTH-1:0];
                    pwdata_d  = mem.mem_wdata;
                    pwrite_d  = |mem.mem_wstrb;
                    pstrb_d   = (|mem.mem_wstrb) ? mem.mem_wstrb : STRB_READ;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
`ifdef CUSTOM2APB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    if (!pwrite_q) begin
                        rdata_d = apb.PRDATA;
                    end
                    bus_err_d   = apb.PSLVERR;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = RESP;
                end
`ifdef CUSTOM2APB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 16'd1;
                    // Expiry only when PREADY is low, so a late PREADY still completes normally.
                    if (cnt_d == TO_LIMIT) begin
                        rdata_d     = TIMEOUT_RDATA;
                        bus_err_d   = 1'b1;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        mem_ready_d = 1'b1;
                        state_d     = RESP;
                    end
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign apb.PADDR     = paddr_q;
    assign apb.PWDATA    = pwdata_q;
    assign apb.PSTRB     = pstrb_q;
    assign apb.PWRITE    = pwrite_q;
    assign apb.PSEL      = psel_q;
    assign apb.PENABLE   = penable_q;
    assign mem.mem_ready = mem_ready_q;
    assign mem.mem_rdata = rdata_q;
    assign mem.bus_err   = bus_err_q;

endmodule

// File: doc/custom2apb.md
Name: custom2apb

Overview:
- Bridge in the opposite direction to the APB-to-custom adapter: a responder on the custom valid/ready memory bus and an initiator on APB4.
- It sits between the soft core's native memory port and the peripheral APB fabric.
- It converts each core transfer into one APB SETUP/ACCESS transfer, then returns read data and completion to the core.

Parameters:
- ADDR_WIDTH, 32, PADDR width; PADDR = mem_addr[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit. Used only with CUSTOM2APB_TIMEOUT_EN. Legal range 1..65535.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  core request valid
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0000 = read
- mem_rdata  out  32  read data, valid while mem_ready=1
- bus_err  out  1  error flag, valid only with mem_ready
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB4 byte strobes
- PREADY  in  1  completer ready
- PRDATA  in  32  completer read data
- PSLVERR  in  1  completer error

Behaviour:
- Interface: reset resetn, asynchronous, active-low; clock clk.
- Reset values: every output is 0; the state machine is in IDLE.
- States IDLE, SETUP, ACCESS, RESP; all outputs are registered.
- IDLE:
  - If mem_valid=1, capture mem_addr, mem_wdata and mem_wstrb into PADDR, PWDATA and PSTRB.
  - Set PWRITE = |mem_wstrb. On reads PSTRB is forced to 0000.
  - Next state SETUP.
- SETUP: PSEL=1, PENABLE=0. Next state ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - While PREADY=0, stay in ACCESS; PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - On PREADY=1:
    - Reads capture PRDATA into mem_rdata.
    - bus_err <= PSLVERR.
    - PSEL and PENABLE drop to 0.
    - Next state RESP.
- RESP:
  - mem_ready=1 for exactly one cycle; mem_rdata and bus_err are valid.
  - Next state IDLE.
  - mem_valid is ignored in RESP, because the core drops mem_valid after sampling mem_ready.
- Latency: mem_valid=1 at edge N gives SETUP at N+1, ACCESS at N+2. With zero wait states, mem_ready=1 at N+3. Each PREADY wait cycle adds 1.
- Data hold rules:
  - mem_rdata holds its last read value after writes and after RESP.
  - bus_err returns to 0 when leaving RESP.
- Back-to-back: a new mem_valid seen in IDLE the cycle after RESP starts immediately. There are no idle APB cycles beyond that one IDLE cycle.
- Core-side inputs are sampled only in IDLE; changes during SETUP or ACCESS are ignored.
- Reset asserted mid-transfer: all outputs go to 0 and the state returns to IDLE immediately. The aborted transfer gets no mem_ready.
- PSEL is 1-bit; address decode is external.

Optional Feature:
- CUSTOM2APB_TIMEOUT_EN defined:
  - A 16-bit counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0: drop PSEL and PENABLE, set mem_rdata=32'h0 and bus_err=1, and go to RESP.
  - PREADY=1 in the same cycle as expiry wins: normal completion.
- Undefined: no counter exists, and ACCESS waits on PREADY indefinitely.

Decomposition:
- Package custom2apb_pkg holds:
  - the state enum/localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - STRB_READ=4'b0000;
  - TIMEOUT_RDATA=32'h0.
- No sub-module: the state machine, capture registers and optional counter stay in one module.

Test Plan:
- Read, zero wait: mem_valid with addr 0x0400_0010, wstrb 0000; PREADY=1 at first ACCESS, PRDATA 0x1234_5678 -> PSEL at N+1, PENABLE at N+2, PWRITE=0, PSTRB=0000, mem_ready at N+3 with mem_rdata 0x1234_5678, bus_err=0.
- Write, 3 wait states: addr 0x0400_0020, wdata 0xCAFE_F00D, wstrb 0011 -> PWRITE=1, PSTRB=0011, PWDATA stable across 4 ACCESS cycles, mem_ready at N+6, mem_rdata unchanged.
- Error: read with PSLVERR=1 at completion -> bus_err=1 only in the mem_ready cycle, 0 afterwards.
- Back-to-back: write then read issued the cycle after RESP -> second PSEL rises exactly 2 cycles after the first mem_ready; no duplicate transfer while mem_ready is high.
- Reset mid-ACCESS: drop resetn while PENABLE=1 -> PSEL, PENABLE and mem_ready are 0 asynchronously; after release, a new read completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=4): PREADY held 0 -> PSEL drops after 4 wait cycles, mem_ready with bus_err=1 and mem_rdata=0. Macro off -> still in ACCESS after 1000 cycles.
